// File: rtl/cic_comb_decim.sv
// Decimating N=2, M=1 CIC comb section: keeps one integrator sample in R,
// differentiates twice, scales, saturates and emits one sample per period.
module cic_comb_decim #(
  parameter int NIN    = 40,
  parameter int NOUT   = 16,
  parameter int R      = 20,
  parameter int SHIFT  = 9,
  parameter int WARMUP = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic [NIN-1:0]         din,
  input  logic                   din_valid,
  output logic signed [NOUT-1:0] dout,
  output logic                   dout_valid
);

  localparam logic [7:0] RM1 = 8'(R - 1);
  localparam logic [7:0] WU  = 8'(WARMUP);
  localparam logic       WU0 = (WARMUP == 0);
  localparam logic signed [NIN-1:0] MAXV =
    {{(NIN-NOUT+1){1'b0}}, {(NOUT-1){1'b1}}};
  localparam logic signed [NIN-1:0] MINV = ~MAXV;

  logic [7:0]     r_cnt;
  logic [7:0]     r_wu;
  logic           r_v0, r_v1, r_v2;
  logic [NIN-1:0] r_x, r_xd;
  logic [NIN-1:0] r_c1, r_c1d;
  logic [NIN-1:0] r_c2;

  logic                   w_acc;
  logic                   w_dec;
  logic                   w_ok;
  logic signed [NIN-1:0]  w_sh;
  logic signed [NOUT-1:0] w_sat;

  assign w_acc = en & din_valid;
  assign w_dec = w_acc & (r_cnt == RM1);
  assign w_ok  = WU0 | (r_wu == WU);
  assign w_sh  = $signed(r_c2) >>> SHIFT;

  always_comb begin
    w_sat = w_sh[NOUT-1:0];
    if (w_sh > MAXV)      w_sat = MAXV[NOUT-1:0];
    else if (w_sh < MINV) w_sat = MINV[NOUT-1:0];
  end

  // Comb differences are plain modulo-2^NIN; integrator wrap cancels here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_wu       <= '0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_x        <= '0;
      r_xd       <= '0;
      r_c1       <= '0;
      r_c1d      <= '0;
      r_c2       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (!en) begin
      r_cnt      <= '0;
      r_wu       <= '0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_xd       <= '0;
      r_c1d      <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (w_acc) r_cnt <= w_dec ? 8'd0 : r_cnt + 8'd1;
      r_v0 <= w_dec;
      r_v1 <= r_v0;
      r_v2 <= r_v1;
      if (w_dec) r_x <= din;
      if (r_v0) begin
        r_c1 <= r_x - r_xd;
        r_xd <= r_x;
      end
      if (r_v1) begin
        r_c2  <= r_c1 - r_c1d;
        r_c1d <= r_c1;
      end
      dout_valid <= r_v2 & w_ok;
      if (r_v2) begin
        dout <= w_sat;
        if (!w_ok) r_wu <= r_wu + 8'd1;
      end
    end
  end

endmodule

// File: doc/cic_comb_decim.md
Name: cic_comb_decim

Overview:
Decimating comb section of the CIC demodulation chain. It consumes the per-sample output of the 2-stage integrator and keeps one sample in R. It applies N=2 first-difference comb stages with differential delay M=1, then scales, saturates and emits one filtered sample per decimated period. Default decimation is 320 kHz mixing rate to 16 kHz demod rate (R=20).

Parameters:
NIN, 40, width of integrator samples (signed, modulo-2^NIN arithmetic)
NOUT, 16, width of output sample (signed)
R, 20, decimation factor (2..255)
SHIFT, 9, arithmetic right shift applied to comb result before saturation
WARMUP, 2, decimated outputs suppressed after reset or en rising

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
en  input  1  block enable; low clears filter state
din  input  NIN  integrator output sample, signed
din_valid  input  1  one-cycle strobe per new integrator sample
dout  output  NOUT  decimated filtered sample, signed
dout_valid  output  1  one-cycle strobe, dout valid this cycle

Behaviour:
- Reset (rstn low, async): dec counter=0, all comb regs=0, warm-up counter=0, pipeline valids=0, dout=0, dout_valid=0.
- en low (synchronous, overrides din_valid in the same cycle): clears dec counter, comb delay regs, pipeline valids and warm-up counter. dout holds its last value; dout_valid=0. Sample offered with en low is dropped.
- Decimation: dec counter counts accepted strobes (din_valid & en) 0..R-1, then wraps to 0. The strobe arriving with count==R-1 is the decimated sample (sample R-1, 2R-1, ...). All other strobes only advance the count.
- Pipeline, all registers updated only on the relevant stage-valid:
  - Cycle 0: decimated strobe; x=din.
  - Cycle 1: c1 <= x - x_d; x_d <= x.
  - Cycle 2: c2 <= c1 - c1_d; c1_d <= c1.
  - Cycle 3: dout <= sat(c2 >>> SHIFT); dout_valid pulses if warm-up done.
  - Fixed latency of 3 clocks from the decimated din_valid edge to dout_valid.
- Arithmetic:
  - Comb subtractions are NIN-bit, modulo 2^NIN, with no overflow detection. Wrap-around of integrator values must cancel.
  - The shift is arithmetic (floor toward minus infinity). No rounding.
  - Saturation clamps to [-2^(NOUT-1), 2^(NOUT-1)-1].
- Warm-up: counter increments on each cycle-3 event until it reaches WARMUP. While below WARMUP, dout still updates but dout_valid stays 0. WARMUP=0 means no suppression.
- Back-to-back din_valid on consecutive cycles: counter advances each cycle. The pipeline is fully pipelined, so R>=2 guarantees no stage collision.
- Reset asserted mid-pipeline: in-flight sample discarded, no dout_valid afterwards. Same for en falling mid-pipeline.
- DC gain = (R*M)^N = 400 at default R; bit growth 9 bits.

Test Plan:
- DC ramp, SHIFT=0, WARMUP=0:
  - Stimulus: din = k(k+1)/2 for k=0,1,2,... (double-integrated constant 1), one strobe every 20 clocks.
  - Required: decimated inputs 190, 780, 1770; dout sequence 190, 400, 400, ...
  - Each dout_valid exactly 3 clocks after strobes k=19, 39, 59.
- Warm-up, WARMUP=2, same stimulus:
  - Required: first two decimated outputs give no dout_valid; first dout_valid carries 400.
  - Exactly one dout_valid per 20 input strobes.
- Wrap-around:
  - Stimulus: add constant 2^40-1000 (mod 2^40) to every DC-ramp sample.
  - Required: steady dout=400, identical to the unshifted case.
- Scaling/saturation with DC level d (din = d·k(k+1)/2, mod 2^40):
  - d=32767, SHIFT=9: dout=25599.
  - d=100, SHIFT=0: dout=32767.
  - d=-100, SHIFT=0: dout=-32768.
- en/simultaneity:
  - Stimulus: drop en on the same cycle as the 10th strobe, hold 5 clocks, re-raise.
  - Required: that strobe ignored, counter restarts at 0, next dout_valid after 20 further strobes plus warm-up. dout holds its old value meanwhile.
- Async reset mid-op:
  - Stimulus: pulse rstn low 1 clock after a decimated strobe.
  - Required: dout=0 and dout_valid=0 immediately; no pulse 2 clocks later.
  - Count restarts: next decimated sample is the 20th strobe after release.
